// File: rtl/fc_layer_sequencer_pkg.sv
// fc_layer_sequencer_pkg: shared FSM states, derived widths and output saturation
package fc_layer_sequencer_pkg;
    typedef enum logic [2:0] {IDLE, LOAD, COMPUTE, FLUSH, WRITE} e_fc_state;

    function automatic int idx_w(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction

    function automatic int acc_width(input int pix_w, input int wgt_w, input int in_dim);
        return pix_w + wgt_w + $clog2(in_dim);
    endfunction

    function automatic int out_width(input int pix_w, input int in_dim);
        return pix_w + $clog2(in_dim);
    endfunction

    // Clamp v to the signed range of a w-bit result
    function automatic logic signed [63:0] sat(input logic signed [63:0] v, input int w);
        logic signed [63:0] hi, lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        return v > hi ? hi : v < lo ? lo : v;
    endfunction
endpackage

// File: rtl/fc_layer_sequencer_if.sv
// fc_layer_sequencer_if: input stream, weight/bias ROM ports and result stream
interface fc_layer_sequencer_if #(
    parameter int PIX_WIDTH     = 8,
    parameter int WEIGHT_WIDTH  = 10,
    parameter int IN_DIMENSION  = 200,
    parameter int OUT_DIMENSION = 64
);
    import fc_layer_sequencer_pkg::*;
    localparam int WA = idx_w(IN_DIMENSION * OUT_DIMENSION);
    localparam int NW = idx_w(OUT_DIMENSION);
    localparam int OW = out_width(PIX_WIDTH, IN_DIMENSION);

    logic [PIX_WIDTH-1:0]    i_data;
    logic                    i_valid, i_sop, i_eop, o_ready;
    logic [WA-1:0]           o_w_addr;
    logic                    o_w_rd;
    logic [WEIGHT_WIDTH-1:0] i_w_data;
    logic [NW-1:0]           o_b_addr;
    logic [WEIGHT_WIDTH-1:0] i_b_data;
    logic [OW-1:0]           o_data;
    logic                    o_valid, o_sop, o_eop, i_ready, o_err;

    modport slave (
        input  i_data, i_valid, i_sop, i_eop, i_w_data, i_b_data, i_ready,
        output o_ready, o_w_addr, o_w_rd, o_b_addr, o_data, o_valid, o_sop, o_eop, o_err
    );
    modport master (
        output i_data, i_valid, i_sop, i_eop, i_w_data, i_b_data, i_ready,
        input  o_ready, o_w_addr, o_w_rd, o_b_addr, o_data, o_valid, o_sop, o_eop, o_err
    );
endinterface

// File: rtl/fc_layer_sequencer_buffer.sv
// fc_layer_sequencer_buffer: input vector store with one write port and one registered read port
module fc_layer_sequencer_buffer #(
    parameter int DEPTH = 200,
    parameter int WIDTH = 8,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             clk_en,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);
    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk)
        if (clk_en) begin
            if (we_i) mem_q[waddr_i] <= wdata_i;
            rdata_o <= mem_q[raddr_i];
        end
endmodule

// File: rtl/fc_layer_sequencer.sv
// fc_layer_sequencer: buffers one input vector, then walks the weight ROM neuron by neuron
// through a single signed MAC and streams out saturated (acc+bias)>>>FRACT per neuron.
module fc_layer_sequencer
    import fc_layer_sequencer_pkg::*;
#(
    parameter int PIX_WIDTH          = 8,
    parameter int WEIGHT_WIDTH       = 10,
    parameter int WEIGHT_FRACT_WIDTH = 5,
    parameter int IN_DIMENSION       = 200,
    parameter int OUT_DIMENSION      = 64
) (
    input logic clk,
    input logic clk_en,
    input logic rst,
    fc_layer_sequencer_if.slave bus
);
    localparam int KW    = $clog2(IN_DIMENSION);
    localparam int NW    = idx_w(OUT_DIMENSION);
    localparam int WA    = idx_w(IN_DIMENSION * OUT_DIMENSION);
    localparam int PW    = PIX_WIDTH + WEIGHT_WIDTH;
    localparam int ACC_W = acc_width(PIX_WIDTH, WEIGHT_WIDTH, IN_DIMENSION);
    localparam int SUM_W = ACC_W + 1;
    localparam int OUT_W = out_width(PIX_WIDTH, IN_DIMENSION);

    e_fc_state state_q, state_d;
    logic [KW-1:0] k_q, k_d, buf_waddr;
    logic [NW-1:0] n_q, n_d;
    logic ready_q, err_q, err_d, buf_we, load_out, beat, k_last, n_last;
    logic mac_en_q, mac_first_q;
    logic [PIX_WIDTH-1:0] x_rd;
    logic signed [PW-1:0] prod;
    logic signed [ACC_W-1:0] acc_q;
    logic signed [SUM_W-1:0] sum_w;
    logic signed [OUT_W-1:0] o_data_q;
    logic o_valid_q, o_sop_q, o_eop_q;

    fc_layer_sequencer_buffer #(.DEPTH(IN_DIMENSION), .WIDTH(PIX_WIDTH)) u_buf (
        .clk(clk), .clk_en(clk_en), .we_i(buf_we), .waddr_i(buf_waddr),
        .wdata_i(bus.i_data), .raddr_i(k_q), .rdata_o(x_rd)
    );

    assign beat   = bus.i_valid && ready_q;
    assign k_last = k_q == KW'(IN_DIMENSION - 1);
    assign n_last = n_q == NW'(OUT_DIMENSION - 1);
    assign prod   = PW'($signed(bus.i_w_data)) * PW'($signed(x_rd));
    assign sum_w  = SUM_W'(acc_q) + SUM_W'($signed(bus.i_b_data));

    assign bus.o_ready  = ready_q;
    assign bus.o_w_rd   = state_q == COMPUTE;
    assign bus.o_w_addr = WA'(n_q) * WA'(IN_DIMENSION) + WA'(k_q);
    assign bus.o_b_addr = n_q;
    assign bus.o_data   = o_data_q;
    assign bus.o_valid  = o_valid_q;
    assign bus.o_sop    = o_sop_q;
    assign bus.o_eop    = o_eop_q;
    assign bus.o_err    = err_q;

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        n_d       = n_q;
        err_d     = 1'b0;
        buf_we    = 1'b0;
        buf_waddr = bus.i_sop ? '0 : k_q;
        load_out  = 1'b0;
        case (state_q)
            IDLE: if (beat) begin
                buf_we  = bus.i_sop;
                err_d   = !bus.i_sop;
                k_d     = bus.i_sop ? KW'(1) : k_q;
                state_d = bus.i_sop ? LOAD : IDLE;
            end
            LOAD: if (beat) begin
                buf_we = 1'b1;
                if (bus.i_sop) begin
                    k_d   = KW'(1);
                    err_d = 1'b1;
                end else if (k_last) begin
                    k_d     = '0;
                    n_d     = '0;
                    err_d   = !bus.i_eop;
                    state_d = COMPUTE;
                end else if (bus.i_eop) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else k_d = k_q + KW'(1);
            end
            COMPUTE: begin
                k_d     = k_last ? '0 : k_q + KW'(1);
                state_d = k_last ? FLUSH : COMPUTE;
            end
            FLUSH: state_d = WRITE;
            WRITE: if (!(o_valid_q && !bus.i_ready)) begin
                load_out = 1'b1;
                n_d      = n_last ? n_q : n_q + NW'(1);
                state_d  = n_last ? IDLE : COMPUTE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk)
        if (rst) begin
            state_q     <= IDLE;
            k_q         <= '0;
            n_q         <= '0;
            ready_q     <= 1'b0;
            err_q       <= 1'b0;
            mac_en_q    <= 1'b0;
            mac_first_q <= 1'b0;
            acc_q       <= '0;
            o_data_q    <= '0;
            o_valid_q   <= 1'b0;
            o_sop_q     <= 1'b0;
            o_eop_q     <= 1'b0;
        end else if (clk_en) begin
            state_q     <= state_d;
            k_q         <= k_d;
            n_q         <= n_d;
            ready_q     <= state_d == IDLE || state_d == LOAD;
            err_q       <= err_d;
            // weight and pixel arrive one cycle after their address, so the MAC trails by one
            mac_en_q    <= state_q == COMPUTE;
            mac_first_q <= k_q == '0;
            if (mac_en_q) acc_q <= mac_first_q ? ACC_W'(prod) : acc_q + ACC_W'(prod);
            if (load_out) begin
                o_data_q  <= OUT_W'(sat(64'(sum_w >>> WEIGHT_FRACT_WIDTH), OUT_W));
                o_valid_q <= 1'b1;
                o_sop_q   <= n_q == '0;
                o_eop_q   <= n_last;
            end else if (bus.i_ready) begin
                o_valid_q <= 1'b0;
                o_sop_q   <= 1'b0;
                o_eop_q   <= 1'b0;
            end
        end
endmodule
